and_result_fifo: RTL
====================

Name: and_result_fifo

Overview:
- Downstream buffer stage for the 8-bit result bus Y of tt_um_clk_and.
- Captures each result the AND stage marks valid into a small first-word-fall-through (FWFT) FIFO.
- Presents results to the pin-side consumer with a valid/ready handshake, so a slow or stalled consumer does not lose results.
- Reports occupancy and a sticky overflow flag for results the producer offered while the FIFO was full.

Parameters:
- WIDTH, 8, data width in bits; matches the Y result bus.
- DEPTH, 4, number of entries; must be a power of two, ≥2.
- ADDR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising clk.
- in_data  input  WIDTH  result word from the AND stage (Y).
- in_valid  input  1  in_data holds a new result this cycle.
- in_ready  output  1  FIFO can accept a word this cycle.
- out_data  output  WIDTH  head-of-FIFO word; forced to 0 when out_valid=0.
- out_valid  output  1  FIFO is non-empty; out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  ADDR_W+1  current occupancy, range 0..DEPTH.
- overflow  output  1  sticky flag: a word was offered while the FIFO was full.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1, out_data=0, overflow=0.
- Reset mid-operation: all stored words are discarded; storage contents need not be cleared.
- Push: occurs when in_valid && in_ready. Writes in_data to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- Status outputs:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - out_data = out_valid ? mem[rd_ptr] : 0.
- Count update: count += push − pop, once per cycle.
- Latency: a word pushed in cycle N appears on out_data with out_valid=1 in cycle N+1. There is no same-cycle bypass.
- Empty with in_valid=1: push only. out_valid rises next cycle.
- Full: in_ready=0, so any offered word is rejected even if out_ready=1 that cycle. There is no combinational path from out_ready to in_ready.
  - A full FIFO with a pop frees one slot, and in_ready=1 in the next cycle.
- Non-empty, non-full, push and pop together: both occur and count is unchanged.
- Overflow: set to 1 in the cycle after any cycle with in_valid=1 && in_ready=0. It is cleared only by reset. The offered word is dropped.
- Pointer wrap: pointers wrap DEPTH−1 → 0 with no gap. Ordering is strictly FIFO across the wrap.
- out_data stability: the consumer sees out_data stable while out_valid=1 && out_ready=0.
- Consumer-side rules: out_ready is ignored when out_valid=0. The producer may drop in_valid at any time without a handshake penalty.
- Implementation: register array plus binary pointers and an explicit count register. Full and empty are derived from count, not from pointer comparison.

Test Plan:
- Reset, then push 0x3C with out_ready=0 → next cycle out_valid=1, out_data=0x3C, count=1, in_ready=1, overflow=0.
- Push 0x01,0x02,0x03,0x04 on consecutive cycles with out_ready=0 → count=4, in_ready=0. A fifth push of 0x05 → overflow=1 next cycle, count stays 4. Then drain with out_ready=1 → 0x01,0x02,0x03,0x04 in order, then out_valid=0 and out_data=0.
- Hold in_valid=1 and out_ready=1 continuously with data 0x10..0x1F (16 words) → every word emerges in order one cycle after push; count stays at 1 and pointers wrap 4 times.
- Fill to 4, then assert in_valid=1 (0xAA) and out_ready=1 in the same cycle → 0xAA rejected and overflow=1. Next cycle count=3 and in_ready=1; a push of 0xAA is then accepted as the last entry.
- With count=3 and overflow=1, assert reset for one cycle → count=0, out_valid=0, out_data=0, overflow=0, in_ready=1. A subsequent push of 0x55 reads back as 0x55.
- Hold out_ready=0 for 10 cycles with count=2 → out_data holds the head value unchanged for all 10 cycles and count stays 2.

Source files
------------

// File: rtl/and_result_fifo.sv
// First-word-fall-through result buffer behind the AND stage.
// Keeps results in order and flags any word offered while the buffer is full.
module and_result_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_reject;
  logic [ADDR_W:0]   w_count_nxt;

  // Status comes only from the count register, so out_ready never reaches in_ready.
  assign w_full   = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_empty  = (r_count == {(ADDR_W+1){1'b0}});
  assign w_push   = in_valid && !w_full;
  assign w_pop    = out_ready && !w_empty;
  assign w_reject = in_valid && w_full;

  // Occupancy update: push and pop together leave the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + (ADDR_W+1)'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - (ADDR_W+1)'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Storage write; contents survive reset because the pointers discard them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= {ADDR_W{1'b0}};
      r_rd_ptr   <= {ADDR_W{1'b0}};
      r_count    <= {(ADDR_W+1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_count <= w_count_nxt;
      if (w_reject) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    in_ready  = !w_full;
    out_valid = !w_empty;
    count     = r_count;
    overflow  = r_overflow;
    if (!w_empty) begin
      out_data = r_mem[r_rd_ptr];
    end else begin
      out_data = {WIDTH{1'b0}};
    end
  end

endmodule
